// File: rtl/core_dg_enc_pkg.sv
// core_pkg: shared types, FIFO depth and the Hamming(7,4) encoder used by
// the core-to-router encoder (and by the decoder bench).
package core_pkg;

    typedef logic [3:0]  ip_t;
    typedef logic [3:0]  nibble_t;
    typedef logic [6:0]  codeword_t;
    typedef logic [7:0]  db_word_t;
    typedef logic [10:0] rtr_pkt_t;

    localparam int FIFO_DEPTH = 2;

    // Data bits sit at c2/c4/c5/c6, parity at c0/c1/c3, matching the decoder.
    function automatic codeword_t hamming74_encode(input nibble_t d);
        codeword_t c;
        c[2] = d[0];
        c[4] = d[1];
        c[5] = d[2];
        c[6] = d[3];
        c[0] = d[0] ^ d[1] ^ d[3];
        c[1] = d[0] ^ d[2] ^ d[3];
        c[3] = d[1] ^ d[2] ^ d[3];
        return c;
    endfunction

endpackage

// File: rtl/core_dg_enc_if.sv
// Handshake bundle between the core (master) and the encoder (slave):
// an input word channel and an output router-packet channel.
interface core_dg_enc_if
    import core_pkg::*;
    ();

    logic     in_valid;
    logic     in_ready;
    db_word_t in_data;
    logic     out_valid;
    logic     out_ready;
    rtr_pkt_t out_data;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );

endinterface

// File: rtl/core_dg_enc_fifo.sv
// Two-entry packet FIFO with 1-bit pointers and a 2-bit count. The head
// packet is kept in its own register so out_data holds its last value
// when the FIFO drains and never depends combinationally on wdata.
module core_dg_enc_fifo
    import core_pkg::*;
(
    input  logic     clk,
    input  logic     rst_n,
    input  logic     push,
    input  logic     pop,
    input  rtr_pkt_t wdata,
    output logic     in_ready,
    output logic     out_valid,
    output rtr_pkt_t rdata
);

    localparam logic [1:0] FULL_COUNT = 2'(FIFO_DEPTH);

    rtr_pkt_t   mem_r [FIFO_DEPTH];
    logic       rd_ptr_r;
    logic       wr_ptr_r;
    logic [1:0] count_r;
    rtr_pkt_t   head_r;

    logic       push_s;
    logic       pop_s;
    logic       rd_ptr_next_s;
    logic [1:0] count_next_s;
    rtr_pkt_t   head_next_s;

    assign in_ready  = (count_r != FULL_COUNT);
    assign out_valid = (count_r != 2'd0);
    assign rdata     = head_r;

    // Next-state decode: qualified push/pop, new count and new head packet.
    always_comb begin
        push_s        = push & (count_r != FULL_COUNT);
        pop_s         = pop & (count_r != 2'd0);
        rd_ptr_next_s = pop_s ? ~rd_ptr_r : rd_ptr_r;
        case ({push_s, pop_s})
            2'b10:   count_next_s = count_r + 2'd1;
            2'b01:   count_next_s = count_r - 2'd1;
            default: count_next_s = count_r;
        endcase
        if (count_next_s == 2'd0) begin
            head_next_s = head_r;
        end else if (push_s && (wr_ptr_r == rd_ptr_next_s)) begin
            head_next_s = wdata;
        end else begin
            head_next_s = mem_r[rd_ptr_next_s];
        end
    end

    // Storage, pointers, count and head register; reset discards contents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= 11'd0;
            end
            rd_ptr_r <= 1'b0;
            wr_ptr_r <= 1'b0;
            count_r  <= 2'd0;
            head_r   <= 11'd0;
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= wdata;
                wr_ptr_r        <= ~wr_ptr_r;
            end
            rd_ptr_r <= rd_ptr_next_s;
            count_r  <= count_next_s;
            head_r   <= head_next_s;
        end
    end

endmodule

// File: rtl/core_dg_enc.sv
// core_dg_enc: Hamming(7,4)-encodes the data nibble of each core word and
// queues {codeword, ip} router packets in a 2-entry FIFO; counts pops.
// Optional feature macro: CORE_DG_ENC_ERR_INJ_EN (XOR err_inj_mask into the
// codeword at push). Without it the mask port is present but ignored.
module core_dg_enc
    import core_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    core_dg_enc_if.slave        bus,
    input  logic [6:0]          err_inj_mask,
    output logic [15:0]         tx_count
);

    logic      push_s;
    logic      pop_s;
    codeword_t cw_s;
    rtr_pkt_t  pkt_s;
    logic [15:0] tx_count_r;

    assign push_s = bus.in_valid & bus.in_ready;
    assign pop_s  = bus.out_valid & bus.out_ready;

`ifdef CORE_DG_ENC_ERR_INJ_EN
    assign cw_s = hamming74_encode(bus.in_data[7:4]) ^ err_inj_mask;
`else
    logic unused_mask_s;
    assign unused_mask_s = ^err_inj_mask;
    assign cw_s = hamming74_encode(bus.in_data[7:4]);
`endif

    assign pkt_s    = {cw_s, bus.in_data[3:0]};
    assign tx_count = tx_count_r;

    core_dg_enc_fifo u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_s),
        .pop       (pop_s),
        .wdata     (pkt_s),
        .in_ready  (bus.in_ready),
        .out_valid (bus.out_valid),
        .rdata     (bus.out_data)
    );

    // Popped-packet counter, wraps modulo 2^16.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_count_r <= 16'd0;
        end else if (pop_s) begin
            tx_count_r <= tx_count_r + 16'd1;
        end else begin
            tx_count_r <= tx_count_r;
        end
    end

endmodule

// File: tb/tb_core_dg_enc.sv
// Directed self-checking bench for core_dg_enc.
module tb_core_dg_enc;
    import core_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [6:0]  err_inj_mask;
    logic [15:0] tx_count;
    int          n_checks;
    int          n_fail;
    int          exp_tx;

    core_dg_enc_if bus ();

    core_dg_enc dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus),
        .err_inj_mask (err_inj_mask),
        .tx_count     (tx_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model built from generator-matrix rows (d0..d3).
    function automatic logic [10:0] model(input logic [7:0] w);
        logic [6:0] c;
        c = 7'd0;
        if (w[4]) c = c ^ 7'b0000111;
        if (w[5]) c = c ^ 7'b0011001;
        if (w[6]) c = c ^ 7'b0101010;
        if (w[7]) c = c ^ 7'b1001011;
        return {c, w[3:0]};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Push one word while draining, check packet and pop.
    task automatic push_pop(input string tag, input logic [7:0] w, input logic [10:0] exp_pkt);
        bus.in_data  = w;
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b1;
        step();
        bus.in_valid = 1'b0;
        check_eq({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
        check_eq({tag, "_data"}, 32'(bus.out_data), 32'(exp_pkt));
        step();
        exp_tx++;
        check_eq({tag, "_tx"}, 32'(tx_count), 32'(exp_tx));
        check_eq({tag, "_empty"}, 32'(bus.out_valid), 32'd0);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        exp_tx   = 0;
        rst_n    = 1'b0;
        err_inj_mask  = 7'd0;
        bus.in_valid  = 1'b0;
        bus.in_data   = 8'd0;
        bus.out_ready = 1'b0;
        #12;
        check_eq("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check_eq("rst_in_ready",  32'(bus.in_ready),  32'd1);
        check_eq("rst_out_data",  32'(bus.out_data),  32'd0);
        check_eq("rst_tx_count",  32'(tx_count),      32'd0);
        step();
        rst_n = 1'b1;

        // Encode check and hold-on-empty.
        push_pop("enc_b5", 8'hB5, 11'h555);
        check_eq("hold_last", 32'(bus.out_data), 32'h555);

        // Code extremes.
        push_pop("enc_13", 8'h13, 11'h073);
        push_pop("enc_fa", 8'hFA, 11'h7FA);
        push_pop("enc_0c", 8'h0C, 11'h00C);

        // Backpressure: fill, hold a third word, then drain.
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 8'h13;
        step();
        check_eq("bp_ready1", 32'(bus.in_ready), 32'd1);
        bus.in_data = 8'hFA;
        step();
        bus.in_data = 8'h0C;
        check_eq("bp_full", 32'(bus.in_ready), 32'd0);
        check_eq("bp_head", 32'(bus.out_data), 32'h073);
        step();
        check_eq("bp_still_full", 32'(bus.in_ready), 32'd0);
        check_eq("bp_stable", 32'(bus.out_data), 32'h073);
        bus.out_ready = 1'b1;
        step();
        exp_tx++;
        check_eq("bp_pop2", 32'(bus.out_data), 32'h7FA);
        check_eq("bp_ready_again", 32'(bus.in_ready), 32'd1);
        step();
        exp_tx++;
        bus.in_valid = 1'b0;
        check_eq("bp_third", 32'(bus.out_data), 32'h00C);
        check_eq("bp_third_valid", 32'(bus.out_valid), 32'd1);
        step();
        exp_tx++;
        check_eq("bp_drained", 32'(bus.out_valid), 32'd0);
        check_eq("bp_tx", 32'(tx_count), 32'(exp_tx));

        // Reset with two packets buffered, no clock edge.
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 8'h13;
        step();
        bus.in_data = 8'hB5;
        step();
        bus.in_valid = 1'b0;
        check_eq("mid_full", 32'(bus.in_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        check_eq("mid_rst_data",  32'(bus.out_data),  32'd0);
        check_eq("mid_rst_tx",    32'(tx_count),      32'd0);
        check_eq("mid_rst_ready", 32'(bus.in_ready),  32'd1);
        step();
        rst_n = 1'b1;
        exp_tx = 0;

        // Streaming all 256 words back-to-back.
        bus.out_ready = 1'b1;
        for (int i = 0; i < 256; i++) begin
            bus.in_data  = 8'(i);
            bus.in_valid = 1'b1;
            step();
            check_eq("stream_valid", 32'(bus.out_valid), 32'd1);
            check_eq("stream_data", 32'(bus.out_data), 32'(model(8'(i))));
        end
        bus.in_valid = 1'b0;
        step();
        check_eq("stream_tx", 32'(tx_count), 32'd256);
        check_eq("stream_empty", 32'(bus.out_valid), 32'd0);
        exp_tx = 256;

`ifdef CORE_DG_ENC_ERR_INJ_EN
        err_inj_mask = 7'h08;
        push_pop("inj_b5", 8'hB5, 11'h5D5);
        err_inj_mask = 7'h00;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/core_dg_enc.md
# core_dg_enc

Clocked transmit-side packet encoder for the core-to-router path. It accepts 8-bit core words, formatted as | 4-bit data | 4-bit destination IP |, and Hamming(7,4)-encodes the data nibble. It buffers up to two encoded packets and presents 11-bit router packets, formatted as | 7-bit codeword | 4-bit IP |. The codeword bit order matches the router-to-data-bucket decoder exactly, so a packet passed through this block and then the decoder returns the original 8-bit word.

## Interface
- No parameters.
- clk  in  1  sole clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  block can accept a word this cycle.
- in_data  in  8  [7:4] data nibble d3..d0, [3:0] destination IP.
- out_valid  out  1  out_data holds a packet.
- out_ready  in  1  router accepts the packet this cycle.
- out_data  out  11  [10:4] codeword c6..c0, [3:0] destination IP.
- err_inj_mask  in  7  bits XORed into the codeword at push (see Configuration).
- tx_count  out  16  count of packets popped, wraps modulo 2^16.

## Operation
- Codeword mapping: c2=d0, c4=d1, c5=d2, c6=d3.
- Parity bits:
  - c0 = d0^d1^d3
  - c1 = d0^d2^d3
  - c3 = d1^d2^d3
- Encoding happens at push. The FIFO stores the full 11-bit packet. The IP field passes through unchanged.
- FIFO:
  - 2 entries, with a read pointer, a write pointer (1 bit each) and count (2 bits, range 0..2).
  - Push = in_valid & in_ready.
  - Pop = out_valid & out_ready.
  - Push and pop may occur in the same cycle: count is unchanged, and both pointers advance modulo 2.
- Control:
  - in_ready = (count != 2), decoded from registers only.
  - out_valid = (count != 0).
  - out_data = entry[rd_ptr], driven from a register with no combinational path from in_data.
- Full: in_ready=0. A pop in that cycle does not enable a same-cycle push; the push is accepted in the following cycle.
- Empty: out_valid=0 and out_data holds its last value. Consumers must not sample out_data while out_valid=0.
- tx_count increments by 1 on each pop; 16'hFFFF wraps to 0.
- Async reset, including mid-transfer:
  - count, pointers and tx_count go to 0.
  - out_valid=0, out_data=0, in_ready=1.
  - Buffered packets are discarded.
  - First acceptance occurs on the first rising edge after rst_n deasserts.

## Timing
- Latency: a word pushed at edge N appears with out_valid=1 in the cycle after edge N (1 cycle).
- Throughput: 1 packet per cycle sustained while out_ready=1.
- Backpressure: with out_ready=0, two pushes fill the FIFO and in_ready falls in the cycle after the second push.
- Handshake rules:
  - in_data is sampled only on a push edge.
  - out_data stays stable while out_valid=1 and out_ready=0.
  - Senders must not withdraw valid before ready.

## Configuration
- CORE_DG_ENC_ERR_INJ_EN defined: stored codeword = encoded codeword ^ err_inj_mask, with err_inj_mask sampled at the push edge. This is used to exercise decoder single-bit correction.
- CORE_DG_ENC_ERR_INJ_EN undefined: the err_inj_mask port remains present but is ignored, and no XOR logic is generated.

## Structure
- core_pkg holds:
  - typedefs ip_t (4), nibble_t (4), codeword_t (7), db_word_t (8) and rtr_pkt_t (11);
  - the constant FIFO_DEPTH = 2;
  - function hamming74_encode(nibble_t) returning codeword_t, shared with the decoder bench.
- Sub-module core_dg_enc_fifo: the 2-entry FIFO of rtr_pkt_t with push/pop, pointers and count. The top level holds the encoder, the injection XOR and tx_count.

## Test plan
- Encode check: reset, then push 8'hB5 → out_data=11'h555 one cycle later; with out_ready=1, tx_count=1.
- Code extremes: push 8'h13 → 11'h073; push 8'hFA → 11'h7FA; push 8'h0C → 11'h00C.
- Backpressure: with out_ready=0, push 8'h13, then 8'hFA, then hold a third word → in_ready=0 after the second push. Raising out_ready pops 11'h073 then 11'h7FA, and the third word is accepted one cycle after the first pop.
- Streaming: with out_ready=1, push all 256 input values back-to-back → every output matches the software model with no bubbles, and tx_count=256.
- Reset mid-operation: with two packets buffered, pull rst_n low → out_valid=0, out_data=0, tx_count=0 and in_ready=1 immediately, with no clock edge required.
- Injection (macro defined): push 8'hB5 with err_inj_mask=7'h08 → out_data=11'h5D5; feeding that packet to the decoder yields 8'hB5.
